// File: rtl/peripheral_msi_ahb3_pkg.sv
// Shared AHB3 encodings and arbiter state type for the MSI interconnect.
package peripheral_msi_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWNED  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  function automatic logic htrans_is_xfer(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

  function automatic logic htrans_is_cont(input logic [1:0] t);
    return (t == HTRANS_SEQ) || (t == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/peripheral_msi_arb_rr_select.sv
// Combinational winner picker: highest priority among requesters,
// ties broken by the first requester at or after rr_ptr (wrapping).
module peripheral_msi_arb_rr_select #(
  parameter int MASTERS = 3,
  parameter int PRIO_W  = 2,
  parameter int IDX_W   = 2
) (
  input  logic [MASTERS-1:0]             req,
  input  logic [MASTERS-1:0][PRIO_W-1:0] prio,
  input  logic [IDX_W-1:0]               rr_ptr,
  output logic [MASTERS-1:0]             win_onehot,
  output logic [IDX_W-1:0]               win_idx,
  output logic                           win_any
);

  logic [PRIO_W-1:0] max_prio;
  logic              found;

  function automatic int wrap_idx(input int base, input int k);
    return (base + k) % MASTERS;
  endfunction

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && (prio[i] > max_prio)) max_prio = prio[i];
    end
  end

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      if (!found && req[wrap_idx(int'(rr_ptr), k)] &&
          (prio[wrap_idx(int'(rr_ptr), k)] == max_prio)) begin
        found = 1'b1;
        win_onehot[wrap_idx(int'(rr_ptr), k)] = 1'b1;
        win_idx = IDX_W'(wrap_idx(int'(rr_ptr), k));
      end
    end
  end

  assign win_any = |req;

endmodule

// File: rtl/peripheral_msi_arbiter_ahb3.sv
// Per-slave-port AHB3 arbiter: priority + round-robin, lock and burst aware.
// Optional INCR hold limit built in when PERIPHERAL_MSI_ARB_HOLD_LIMIT_EN is defined.
//
// state      | meaning
// ARB_IDLE   | no address-phase owner
// ARB_OWNED  | owner holds the slave while its HTRANS is SEQ/BUSY
// ARB_LOCKED | owner holds the slave until HMASTLOCK drops at a NONSEQ/IDLE
module peripheral_msi_arbiter_ahb3
  import peripheral_msi_ahb3_pkg::*;
#(
  parameter  int MASTERS    = 3,
  parameter  int PRIO_W     = 2,
  parameter  int HOLD_LIMIT = 16,
  localparam int IDX_W      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                           HRESETn,
  input  logic                           HCLK,
  input  logic [MASTERS-1:0][PRIO_W-1:0] mst_priority,
  input  logic [MASTERS-1:0]             mst_req,
  input  logic [MASTERS-1:0][1:0]        mst_HTRANS,
  input  logic [MASTERS-1:0][2:0]        mst_HBURST,
  input  logic [MASTERS-1:0]             mst_HMASTLOCK,
  input  logic                           slv_HREADY,
  output logic [MASTERS-1:0]             addr_grant,
  output logic [IDX_W-1:0]               addr_grant_idx,
  output logic [MASTERS-1:0]             data_owner,
  output logic                           data_owner_vld,
  output logic                           slv_locked
);

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;
  logic [1:0]         own_trans;
  logic               own_cont;
  logic               force_rearb;
  logic               do_arb;
  logic [MASTERS-1:0] others_req;
  logic [MASTERS-1:0] req_sel;
  logic [MASTERS-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  assign own_trans  = mst_HTRANS[addr_grant_idx];
  assign own_cont   = htrans_is_cont(own_trans);
  assign others_req = mst_req & ~addr_grant;
  // A forced hand-off skips the current owner only if someone else is waiting.
  assign req_sel    = (force_rearb && (|others_req)) ? others_req : mst_req;

  peripheral_msi_arb_rr_select #(
    .MASTERS (MASTERS),
    .PRIO_W  (PRIO_W),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req_sel),
    .prio       (mst_priority),
    .rr_ptr     (rr_ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign rr_next = (win_idx == IDX_W'(MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);

  always_comb begin
    do_arb = 1'b1;
    case (state)
      ARB_OWNED:  do_arb = !(mst_req[addr_grant_idx] && own_cont) || force_rearb;
      ARB_LOCKED: do_arb = !(mst_HMASTLOCK[addr_grant_idx] || own_cont);
      default:    do_arb = 1'b1;
    endcase
  end

`ifdef PERIPHERAL_MSI_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             incr_owner;

  assign incr_owner  = (state == ARB_OWNED) && (mst_HBURST[addr_grant_idx] == HBURST_INCR);
  assign force_rearb = incr_owner && (beat_cnt >= CNT_W'(HOLD_LIMIT));

  // The granting edge consumes the first beat, so a new grant restarts at one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt <= '0;
    end else if (slv_HREADY) begin
      if (do_arb) begin
        beat_cnt <= win_any ? CNT_W'(1) : '0;
      end else if (incr_owner && (beat_cnt < CNT_W'(HOLD_LIMIT))) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic hold_unused;

  assign force_rearb = 1'b0;
  // Burst type and the hold limit only matter when the hold limit is built in.
  assign hold_unused = (^mst_HBURST) ^ (HOLD_LIMIT > 0);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      addr_grant     <= '0;
      addr_grant_idx <= '0;
      data_owner     <= '0;
      data_owner_vld <= 1'b0;
      slv_locked     <= 1'b0;
    end else if (slv_HREADY) begin
      data_owner     <= addr_grant;
      data_owner_vld <= (|addr_grant) && htrans_is_xfer(own_trans);
      if (do_arb) begin
        if (win_any) begin
          addr_grant     <= win_onehot;
          addr_grant_idx <= win_idx;
          rr_ptr         <= rr_next;
          state          <= mst_HMASTLOCK[win_idx] ? ARB_LOCKED : ARB_OWNED;
          slv_locked     <= mst_HMASTLOCK[win_idx];
        end else begin
          addr_grant     <= '0;
          addr_grant_idx <= '0;
          state          <= ARB_IDLE;
          slv_locked     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_peripheral_msi_arbiter_ahb3.sv
// Directed bench for peripheral_msi_arbiter_ahb3 with hand-computed expectations.
module tb_peripheral_msi_arbiter_ahb3;
  import peripheral_msi_ahb3_pkg::*;

  localparam int M = 3;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic [M-1:0][1:0]   mst_priority;
  logic [M-1:0]        mst_req;
  logic [M-1:0][1:0]   mst_HTRANS;
  logic [M-1:0][2:0]   mst_HBURST;
  logic [M-1:0]        mst_HMASTLOCK;
  logic                slv_HREADY;
  logic [M-1:0]        addr_grant;
  logic [1:0]          addr_grant_idx;
  logic [M-1:0]        data_owner;
  logic                data_owner_vld;
  logic                slv_locked;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  peripheral_msi_arbiter_ahb3 #(
    .MASTERS    (M),
    .PRIO_W     (2),
    .HOLD_LIMIT (4)
  ) dut (
    .HRESETn        (HRESETn),
    .HCLK           (HCLK),
    .mst_priority   (mst_priority),
    .mst_req        (mst_req),
    .mst_HTRANS     (mst_HTRANS),
    .mst_HBURST     (mst_HBURST),
    .mst_HMASTLOCK  (mst_HMASTLOCK),
    .slv_HREADY     (slv_HREADY),
    .addr_grant     (addr_grant),
    .addr_grant_idx (addr_grant_idx),
    .data_owner     (data_owner),
    .data_owner_vld (data_owner_vld),
    .slv_locked     (slv_locked)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic drive(input int m, input logic req, input logic [1:0] tr,
                       input logic [2:0] bu, input logic lk);
    mst_req[m]       = req;
    mst_HTRANS[m]    = tr;
    mst_HBURST[m]    = bu;
    mst_HMASTLOCK[m] = lk;
  endtask

  task automatic do_reset();
    mst_priority  = '0;
    mst_req       = '0;
    mst_HTRANS    = '0;
    mst_HBURST    = '0;
    mst_HMASTLOCK = '0;
    slv_HREADY    = 1'b1;
    HRESETn       = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  logic [M-1:0] rot [6];

  initial begin
    rot = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset values
    do_reset();
    check_val("rst_grant", addr_grant, 3'b000);
    check_val("rst_idx", addr_grant_idx, 2'd0);
    check_val("rst_downer", data_owner, 3'b000);
    check_val("rst_dvld", data_owner_vld, 1'b0);
    check_val("rst_locked", slv_locked, 1'b0);

    // Priorities 1,3,3: master1, then master2, then master0
    do_reset();
    mst_priority[0] = 2'd1; mst_priority[1] = 2'd3; mst_priority[2] = 2'd3;
    for (int m = 0; m < M; m++) drive(m, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    step();
    check_val("prio_g1", addr_grant, 3'b010);
    check_val("prio_i1", addr_grant_idx, 2'd1);
    drive(1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    step();
    check_val("prio_g2", addr_grant, 3'b100);
    check_val("prio_i2", addr_grant_idx, 2'd2);
    check_val("prio_d2", data_owner, 3'b010);
    check_val("prio_v2", data_owner_vld, 1'b0);
    drive(2, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    step();
    check_val("prio_g3", addr_grant, 3'b001);
    check_val("prio_i3", addr_grant_idx, 2'd0);

    // Equal priorities, continuous NONSEQ singles rotate 0,1,2,...
    do_reset();
    for (int m = 0; m < M; m++) drive(m, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val($sformatf("rot_g%0d", i), addr_grant, rot[i]);
      if (i > 0) begin
        check_val($sformatf("rot_d%0d", i), data_owner, rot[i-1]);
        check_val($sformatf("rot_v%0d", i), data_owner_vld, 1'b1);
      end
    end

    // INCR4 by master0 is not preempted by a higher-priority master2
    do_reset();
    mst_priority[2] = 2'd3;
    drive(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
    step();
    check_val("burst_g1", addr_grant, 3'b001);
    drive(0, 1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    drive(2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int b = 2; b <= 4; b++) begin
      step();
      check_val($sformatf("burst_g%0d", b), addr_grant, 3'b001);
      check_val($sformatf("burst_d%0d", b), data_owner, 3'b001);
      check_val($sformatf("burst_v%0d", b), data_owner_vld, 1'b1);
    end
    drive(0, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    step();
    check_val("burst_g5", addr_grant, 3'b100);
    check_val("burst_d5", data_owner, 3'b001);
    check_val("burst_v5", data_owner_vld, 1'b0);
    step();
    check_val("burst_d6", data_owner, 3'b100);
    check_val("burst_v6", data_owner_vld, 1'b1);

    // Locked master1 holds off higher-priority master0
    do_reset();
    mst_priority[0] = 2'd3;
    drive(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    step();
    check_val("lock_g1", addr_grant, 3'b010);
    check_val("lock_l1", slv_locked, 1'b1);
    drive(0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    step();
    check_val("lock_g2", addr_grant, 3'b010);
    check_val("lock_l2", slv_locked, 1'b1);
    drive(1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    step();
    check_val("lock_g3", addr_grant, 3'b001);
    check_val("lock_l3", slv_locked, 1'b0);

    // HREADY stall freezes everything, including the round-robin pointer
    do_reset();
    drive(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
    step();
    check_val("stall_g1", addr_grant, 3'b001);
    drive(0, 1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    step();
    check_val("stall_d2", data_owner, 3'b001);
    slv_HREADY = 1'b0;
    mst_priority[1] = 2'd3; mst_priority[2] = 2'd3;
    drive(0, 1'b0, HTRANS_IDLE, HBURST_INCR4, 1'b0);
    drive(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    drive(2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step();
      check_val($sformatf("stall_hold_g%0d", s), addr_grant, 3'b001);
      check_val($sformatf("stall_hold_d%0d", s), data_owner, 3'b001);
      check_val($sformatf("stall_hold_v%0d", s), data_owner_vld, 1'b1);
    end
    slv_HREADY = 1'b1;
    drive(0, 1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    step();
    check_val("stall_resume_g", addr_grant, 3'b001);
    drive(0, 1'b0, HTRANS_IDLE, HBURST_INCR4, 1'b0);
    step();
    check_val("stall_after_g", addr_grant, 3'b010);
    check_val("stall_after_i", addr_grant_idx, 2'd1);
    step();
    check_val("stall_next_g", addr_grant, 3'b100);
    check_val("stall_next_i", addr_grant_idx, 2'd2);
    HRESETn = 1'b0;
    #2;
    check_val("async_rst_g", addr_grant, 3'b000);
    check_val("async_rst_i", addr_grant_idx, 2'd0);
    check_val("async_rst_d", data_owner, 3'b000);
    check_val("async_rst_v", data_owner_vld, 1'b0);
    check_val("async_rst_l", slv_locked, 1'b0);

    // Long INCR by master0 with master1 waiting (hold limit 4 when built in)
    do_reset();
    drive(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 1'b0);
    drive(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    step();
    check_val("hold_g1", addr_grant, 3'b001);
    drive(0, 1'b1, HTRANS_SEQ, HBURST_INCR, 1'b0);
`ifdef PERIPHERAL_MSI_ARB_HOLD_LIMIT_EN
    for (int b = 2; b <= 4; b++) begin
      step();
      check_val($sformatf("hold_g%0d", b), addr_grant, 3'b001);
    end
    step();
    check_val("hold_g5", addr_grant, 3'b010);
`else
    for (int b = 2; b <= 10; b++) begin
      step();
      check_val($sformatf("hold_g%0d", b), addr_grant, 3'b001);
    end
    drive(0, 1'b0, HTRANS_IDLE, HBURST_INCR, 1'b0);
    step();
    check_val("hold_g11", addr_grant, 3'b010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
